sccomp_soc: RTL and testbench
=============================

Name: sccomp_soc

Overview:
Parametrised successor to the single-cycle computer top. Wraps the existing cpu, imem and dmem and adds a divided CPU clock with a run/halt/single-step controller. Adds a memory-mapped I/O window holding a display register, a switch input and a CPU-cycle counter. This block is the board-level top for FPGA bring-up and debug.

Parameters:
DIV, 4, clk_in cycles per CPU clock half-period; legal range 1..2^24; one CPU cycle is 2*DIV clk_in cycles.
IMEM_AW, 11, imem word-address width; imem is addressed with pc[IMEM_AW+1:2].
IO_BASE, 32'h1000_0000, base byte address of the I/O window; window covers IO_BASE..IO_BASE+'hF.
SW_W, 16, switch input width.

Ports:
clk_in  input  1  board clock.
reset_n  input  1  asynchronous active-low reset.
halt_req  input  1  level; high requests halt, low requests run.
step_req  input  1  level; a rising edge while halted executes exactly one instruction.
sw  input  SW_W  board switches.
inst  output  32  current instruction.
pc  output  32  current PC.
disp  output  32  display register.
halted  output  1  high while in HALT.
cpu_clk  output  1  divided CPU clock, for observation.

Behaviour:
- Reset.
  - reset_n low asynchronously forces: cpu_clk=0, divider count=0, FSM=HALT, halted=1, disp=0, cycle counter=0.
  - cpu and dmem receive reset = ~reset_n, so pc follows the cpu reset value.
  - Leaving reset, the FSM goes to RUN on the first clk_in edge if halt_req=0.
- Input synchronisation: halt_req and step_req each pass through a 2-flop synchroniser. step edge = sync & ~sync_d.
- Divider.
  - When the FSM is RUN or STEP, the count increments each clk_in cycle.
  - At count==DIV-1, count returns to 0 and cpu_clk toggles.
  - rise_tick is a one-clk_in pulse on the cycle where cpu_clk goes 0->1.
  - cpu and dmem are clocked by cpu_clk.
- FSM with states HALT, RUN, STEP:
  - HALT: cpu_clk held 0, count held 0. Step edge -> STEP. halt_req=0 -> RUN. If both occur in the same cycle, step wins.
  - RUN: a halt_req=1 sample is latched. The FSM moves to HALT only when cpu_clk falls 1->0, so the current CPU cycle always completes and no partial instruction occurs.
  - STEP: exactly one cpu_clk rising edge, then HALT on the following 1->0 transition. halt_req is ignored during STEP.
  - halted = (state==HALT).
- I/O decode.
  - io_sel = DM_CS and (addr & ~32'hF)==IO_BASE.
  - dmem chip-select is DM_CS & ~io_sel.
  - Offset 0x0: disp, read/write. Offset 0x4: {zero-extend, sw}, read-only. Offset 0x8: cycle counter, read-only. Offset 0xC: reads 0.
  - Writes to read-only offsets are ignored.
  - Reads into the cpu are combinational: rdata = io_sel ? io_rdata : dmem rdata.
- Write timing: disp is updated on clk_in when rise_tick & io_sel & DM_W & offset==0. The value is the full 32-bit wdata; DM_W_CS byte/half modes are ignored for I/O.
- Cycle counter: 32-bit, increments on each rise_tick, wraps 0xFFFF_FFFF -> 0. It does not count while halted.
- Reset mid-operation: the asynchronous reset aborts any cycle. Memory contents are not cleared.

Optional Feature:
SEG7_DISP_EN
- Defined: ports o_seg[7:0] and o_sel[7:0] are added, and seg7x16 is instantiated on clk_in/~reset_n.
  - halted=1: displays pc.
  - halted=0: displays disp.
- Undefined: ports and instance are absent; no other behaviour changes.

Decomposition:
- Shared package/header: IO offset constants (IO_DISP=0, IO_SW=4, IO_CYC=8), FSM state encodings (HALT=2'd0, RUN=2'd1, STEP=2'd2).
- One sub-module, sccomp_runctl, owns the synchronisers, divider, FSM and rise_tick.
- I/O decode and registers stay in the top.

Test Plan:
1. Reset: hold reset_n=0 for 5 cycles -> cpu_clk=0, halted=1, disp=0, cycle counter=0. Release with halt_req=0 and DIV=4 -> first cpu_clk rise 4 clk_in cycles after RUN entry, period 8 clk_in cycles.
2. Halt mid-cycle: assert halt_req while cpu_clk=1 -> cpu_clk completes its high phase, falls, then stays 0. halted=1 within DIV+3 clk_in cycles. pc is stable afterwards.
3. Single step: while halted, pulse step_req 3 times, each spaced >4*DIV cycles -> pc advances by exactly 12, cycle counter +3, halted returns to 1 after each step.
4. Step/run collision: step edge and halt_req falling in the same synchronised cycle -> one STEP executes, then RUN.
5. I/O: program does sw 0xDEADBEEF to IO_BASE and lw from IO_BASE+4 with sw=16'hA5A5 -> disp=32'hDEADBEEF and loaded register=32'h0000A5A5. Store to IO_BASE+8 leaves the counter unchanged. The dmem word at the same low address is not written.
6. Counter wrap: force the cycle counter to 0xFFFF_FFFE, run 2 CPU cycles -> value 0x0000_0000.

Source files
------------

// File: rtl/sccomp_soc_pkg.sv
// sccomp_soc_pkg: shared I/O offsets, run-controller state encoding and the
// instruction encodings understood by the bring-up cpu.
`default_nettype none

package sccomp_soc_pkg;

  localparam logic [3:0] IO_DISP = 4'h0;
  localparam logic [3:0] IO_SW   = 4'h4;
  localparam logic [3:0] IO_CYC  = 4'h8;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } run_state_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_WORD  = 3'b010;

endpackage

`default_nettype wire

// File: rtl/cpu.sv
// cpu: single-cycle RV32I subset (lui, addi, lw, sw); unknown opcodes act as nop.
// Register file and pc update on the rising edge of the divided CPU clock.
`default_nettype none

module cpu
  import sccomp_soc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic        dm_cs_o,
  output logic        dm_we_o
);

  logic [31:0] pc_q;
  logic [31:0] rf_q [0:31];
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, wb_val;
  logic        wb_en;

  assign opcode  = inst_i[6:0];
  assign rd      = inst_i[11:7];
  assign funct3  = inst_i[14:12];
  assign rs1     = inst_i[19:15];
  assign rs2     = inst_i[24:20];
  assign imm_i   = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  // Memory-side decode is kept apart from writeback so the read data path
  // never feeds back into the chip-select logic.
  always_comb begin
    dm_cs_o   = 1'b0;
    dm_we_o   = 1'b0;
    dm_addr_o = rs1_val + imm_i;
    if (opcode == OP_LOAD && funct3 == F3_WORD) begin
      dm_cs_o = 1'b1;
    end else if (opcode == OP_STORE && funct3 == F3_WORD) begin
      dm_cs_o   = 1'b1;
      dm_we_o   = 1'b1;
      dm_addr_o = rs1_val + imm_s;
    end
  end

  always_comb begin
    wb_en  = 1'b0;
    wb_val = '0;
    case (opcode)
      OP_LUI: begin
        wb_en  = 1'b1;
        wb_val = {inst_i[31:12], 12'h000};
      end
      OP_IMM: if (funct3 == F3_ADDI) begin
        wb_en  = 1'b1;
        wb_val = rs1_val + imm_i;
      end
      OP_LOAD: if (funct3 == F3_WORD) begin
        wb_en  = 1'b1;
        wb_val = dm_rdata_i;
      end
      default: ;
    endcase
  end

  assign dm_wdata_o = rs2_val;
  assign pc_o       = pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= '0;
    else       pc_q <= pc_q + 32'd4;
  end

  always_ff @(posedge clk_i) begin
    if (wb_en && rd != 5'd0) rf_q[rd] <= wb_val;
  end

endmodule

`default_nettype wire

// File: rtl/dmem.sv
// dmem: word-wide data RAM, combinational read, write on the CPU clock.
// Contents survive reset; reset only blocks writes.
`default_nettype none

module dmem #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (!rst_i && cs_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/imem.sv
// imem: combinational bring-up ROM; exercises the I/O window and dmem, then
// falls through nops so single-stepping advances pc by one word per step.
`default_nettype none

module imem #(
  parameter int unsigned AW = 11
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o
);

  always_comb begin
    rdata_o = 32'h0000_0013;
    case (addr_i)
      AW'(0):  rdata_o = 32'h1230_0213; // addi x4, x0, 0x123
      AW'(1):  rdata_o = 32'h0040_2023; // sw   x4, 0(x0)
      AW'(2):  rdata_o = 32'h0040_2423; // sw   x4, 8(x0)
      AW'(3):  rdata_o = 32'h1000_00B7; // lui  x1, 0x10000
      AW'(4):  rdata_o = 32'hDEAD_C137; // lui  x2, 0xDEADC
      AW'(5):  rdata_o = 32'hEEF1_0113; // addi x2, x2, -273
      AW'(6):  rdata_o = 32'h0020_A023; // sw   x2, 0(x1)
      AW'(7):  rdata_o = 32'h0040_A183; // lw   x3, 4(x1)
      AW'(8):  rdata_o = 32'h0020_A423; // sw   x2, 8(x1)
      AW'(9):  rdata_o = 32'h0000_2283; // lw   x5, 0(x0)
      default: rdata_o = 32'h0000_0013;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sccomp_runctl.sv
// sccomp_runctl: input synchronisers, CPU clock divider and run/halt/step FSM.
// State changes out of RUN/STEP only on a cpu_clk fall so no cycle is cut short.
`default_nettype none

module sccomp_runctl
  import sccomp_soc_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic halt_req_i,
  input  logic step_req_i,
  output logic cpu_clk_o,
  output logic rise_tick_o,
  output logic halted_o
);

  localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);

  logic [1:0]    halt_sync_q, step_sync_q;
  logic          step_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cpu_clk_q, cpu_clk_d;
  logic          halt_pend_q, halt_pend_d;
  run_state_e    state_q, state_d;
  logic          halt_lvl, step_edge, run_en, at_top, fall_tick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halt_sync_q <= '0;
      step_sync_q <= '0;
      step_dly_q  <= 1'b0;
    end else begin
      halt_sync_q <= {halt_sync_q[0], halt_req_i};
      step_sync_q <= {step_sync_q[0], step_req_i};
      step_dly_q  <= step_sync_q[1];
    end
  end

  assign halt_lvl    = halt_sync_q[1];
  assign step_edge   = step_sync_q[1] & ~step_dly_q;
  assign run_en      = (state_q != ST_HALT);
  assign at_top      = (cnt_q == CNT_TOP);
  assign rise_tick_o = run_en & at_top & ~cpu_clk_q;
  assign fall_tick   = run_en & at_top & cpu_clk_q;

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    cnt_d       = cnt_q;
    cpu_clk_d   = cpu_clk_q;
    if (run_en) begin
      if (at_top) begin
        cnt_d     = '0;
        cpu_clk_d = ~cpu_clk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    case (state_q)
      ST_HALT: begin
        halt_pend_d = 1'b0;
        if (step_edge)      state_d = ST_STEP;
        else if (!halt_lvl) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_lvl) halt_pend_d = 1'b1;
        if (fall_tick && (halt_lvl || halt_pend_q)) begin
          state_d     = ST_HALT;
          halt_pend_d = 1'b0;
        end
      end
      ST_STEP: begin
        // Entered with cpu_clk low, so the first fall follows exactly one rise.
        if (fall_tick) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HALT;
      halt_pend_q <= 1'b0;
      cnt_q       <= '0;
      cpu_clk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
      cpu_clk_q   <= cpu_clk_d;
    end
  end

  assign cpu_clk_o = cpu_clk_q;
  assign halted_o  = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: rtl/seg7x16.sv
// seg7x16: 8-digit multiplexed hex display driver, active-low segments and
// digit selects. Only compiled when SEG7_DISP_EN is defined.
`default_nettype none

`ifdef SEG7_DISP_EN
module seg7x16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  output logic [7:0]  seg_o,
  output logic [7:0]  sel_o
);

  logic [16:0] scan_q;
  logic [2:0]  dig;
  logic [3:0]  nib;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) scan_q <= '0;
    else       scan_q <= scan_q + 17'd1;
  end

  assign dig   = scan_q[16:14];
  assign nib   = 4'(data_i >> {dig, 2'b00});
  assign sel_o = ~(8'd1 << dig);

  always_comb begin
    case (nib)
      4'h0: seg_o = 8'hC0;  4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;  4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;  4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;  4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;  4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;  4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;  4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;  default: seg_o = 8'h8E;
    endcase
  end

endmodule
`endif

`default_nettype wire

// File: rtl/sccomp_soc.sv
// sccomp_soc: board top with divided CPU clock, run/halt/step control and an
// I/O window (display, switches, cycle counter). SEG7_DISP_EN adds a 7-seg driver.
`default_nettype none

module sccomp_soc
  import sccomp_soc_pkg::*;
#(
  parameter int unsigned DIV     = 4,
  parameter int unsigned IMEM_AW = 11,
  parameter logic [31:0] IO_BASE = 32'h1000_0000,
  parameter int unsigned SW_W    = 16
) (
  input  logic            clk_in,
  input  logic            reset_n,
  input  logic            halt_req,
  input  logic            step_req,
  input  logic [SW_W-1:0] sw,
  output logic [31:0]     inst,
  output logic [31:0]     pc,
  output logic [31:0]     disp,
  output logic            halted,
  output logic            cpu_clk
`ifdef SEG7_DISP_EN
  ,
  output logic [7:0]      o_seg,
  output logic [7:0]      o_sel
`endif
);

  localparam int unsigned DM_AW = 10;

  logic        cpu_rst, rise_tick;
  logic        dm_cs, dm_we, io_sel, mem_cs;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, mem_rdata, io_rdata;
  logic [31:0] disp_q, cyc_q;

  assign cpu_rst = ~reset_n;

  sccomp_runctl #(.DIV(DIV)) u_runctl (
    .clk_i       (clk_in),
    .rst_ni      (reset_n),
    .halt_req_i  (halt_req),
    .step_req_i  (step_req),
    .cpu_clk_o   (cpu_clk),
    .rise_tick_o (rise_tick),
    .halted_o    (halted)
  );

  cpu u_cpu (
    .clk_i      (cpu_clk),
    .rst_i      (cpu_rst),
    .inst_i     (inst),
    .dm_rdata_i (dm_rdata),
    .pc_o       (pc),
    .dm_addr_o  (dm_addr),
    .dm_wdata_o (dm_wdata),
    .dm_cs_o    (dm_cs),
    .dm_we_o    (dm_we)
  );

  imem #(.AW(IMEM_AW)) u_imem (
    .addr_i  (pc[IMEM_AW+1:2]),
    .rdata_o (inst)
  );

  assign io_sel = dm_cs && ((dm_addr & ~32'hF) == IO_BASE);
  assign mem_cs = dm_cs & ~io_sel;

  dmem #(.AW(DM_AW)) u_dmem (
    .clk_i   (cpu_clk),
    .rst_i   (cpu_rst),
    .cs_i    (mem_cs),
    .we_i    (dm_we),
    .addr_i  (dm_addr[DM_AW+1:2]),
    .wdata_i (dm_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    io_rdata = '0;
    case (dm_addr[3:0])
      IO_DISP: io_rdata = disp_q;
      IO_SW:   io_rdata = 32'(sw);
      IO_CYC:  io_rdata = cyc_q;
      default: io_rdata = '0;
    endcase
  end

  assign dm_rdata = io_sel ? io_rdata : mem_rdata;

  // rise_tick coincides with the cpu_clk rising edge, so I/O writes commit
  // in the same CPU cycle as dmem writes.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      disp_q <= '0;
      cyc_q  <= '0;
    end else if (rise_tick) begin
      cyc_q <= cyc_q + 32'd1;
      if (io_sel && dm_we && dm_addr[3:0] == IO_DISP) disp_q <= dm_wdata;
    end
  end

  assign disp = disp_q;

`ifdef SEG7_DISP_EN
  seg7x16 u_seg7 (
    .clk_i  (clk_in),
    .rst_i  (cpu_rst),
    .data_i (halted ? pc : disp_q),
    .seg_o  (o_seg),
    .sel_o  (o_sel)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_sccomp_soc.sv
// tb_sccomp_soc: directed checks of reset, clock division, halt, single-step,
// step/run collision, I/O window and cycle-counter wrap.
`default_nettype none

module tb_sccomp_soc;
  import sccomp_soc_pkg::*;

  logic        clk_in   = 1'b0;
  logic        reset_n  = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic [15:0] sw       = 16'hA5A5;
  logic [31:0] inst, pc, disp;
  logic        halted, cpu_clk;

  int total = 0;
  int bad   = 0;
  int n_rise = 0;

  sccomp_soc dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .halt_req (halt_req),
    .step_req (step_req),
    .sw       (sw),
    .inst     (inst),
    .pc       (pc),
    .disp     (disp),
    .halted   (halted),
    .cpu_clk  (cpu_clk)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) n_rise <= 0;
    else          n_rise <= n_rise + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_step();
    step_req = 1'b1;
    repeat (3) @(negedge clk_in);
    step_req = 1'b0;
    repeat (20) @(negedge clk_in);
  endtask

  initial begin
    int n;
    int r0;
    logic [31:0] pc0, cyc0;

    // Reset
    repeat (5) @(negedge clk_in);
    chk("rst_cpu_clk", 32'(cpu_clk), 32'd0);
    chk("rst_halted",  32'(halted),  32'd1);
    chk("rst_disp",    disp,         32'd0);
    chk("rst_cyc",     dut.cyc_q,    32'd0);
    chk("rst_pc",      pc,           32'd0);

    reset_n = 1'b1;
    @(posedge clk_in); #1;
    chk("run_entry", 32'(halted), 32'd0);

    n = 0;
    while (!cpu_clk && n < 50) begin @(posedge clk_in); #1; n++; end
    chk("first_rise_delay", n, 32'd4);
    n = 0;
    while (cpu_clk && n < 50)  begin @(posedge clk_in); #1; n++; end
    while (!cpu_clk && n < 50) begin @(posedge clk_in); #1; n++; end
    chk("cpu_clk_period", n, 32'd8);

    // I/O program
    n = 0;
    while (pc < 32'h40 && n < 1000) begin @(negedge clk_in); n++; end
    chk("prog_timeout", 32'(n < 1000), 32'd1);
    chk("io_disp",      disp, 32'hDEAD_BEEF);
    chk("io_sw_load",   dut.u_cpu.rf_q[3], 32'h0000_A5A5);
    chk("dmem_load",    dut.u_cpu.rf_q[5], 32'h0000_0123);
    chk("dmem_word0",   dut.u_dmem.mem_q[0], 32'h0000_0123);
    chk("dmem_word2",   dut.u_dmem.mem_q[2], 32'h0000_0123);
    chk("cyc_vs_rises", dut.cyc_q, 32'(n_rise));
    chk("pc_vs_rises",  pc, 32'(n_rise * 4));

    // Halt right after a cpu_clk rise
    n = 0;
    while (cpu_clk && n < 50)  begin @(negedge clk_in); n++; end
    while (!cpu_clk && n < 50) begin @(negedge clk_in); n++; end
    halt_req = 1'b1;
    n = 0;
    while (!halted && n < 50) begin @(posedge clk_in); #1; n++; end
    chk("halt_latency_ok", 32'(n <= 7), 32'd1);
    chk("halt_clk_low", 32'(cpu_clk), 32'd0);
    pc0 = pc;
    r0  = n_rise;
    repeat (40) @(negedge clk_in);
    chk("halt_pc_stable", pc, pc0);
    chk("halt_no_rise",   32'(n_rise), 32'(r0));
    chk("halt_clk_held",  32'(cpu_clk), 32'd0);

    // Single step x3
    pc0  = pc;
    cyc0 = dut.cyc_q;
    for (int k = 0; k < 3; k++) begin
      do_step();
      chk("step_rehalted", 32'(halted), 32'd1);
    end
    chk("step_pc",  pc, pc0 + 32'd12);
    chk("step_cyc", dut.cyc_q, cyc0 + 32'd3);

    // Counter wrap
    @(negedge clk_in);
    force dut.cyc_q = 32'hFFFF_FFFE;
    @(negedge clk_in);
    release dut.cyc_q;
    do_step();
    chk("wrap_step1", dut.cyc_q, 32'hFFFF_FFFF);
    do_step();
    chk("wrap_step2", dut.cyc_q, 32'h0000_0000);

    // Step edge and halt release in the same synchronised cycle
    @(negedge clk_in);
    step_req = 1'b1;
    halt_req = 1'b0;
    n = 0;
    while (halted && n < 20) begin @(posedge clk_in); #1; n++; end
    chk("coll_state_step", 32'(dut.u_runctl.state_q), 32'(ST_STEP));
    r0 = n_rise;
    n = 0;
    while (!halted && n < 40) begin @(posedge clk_in); #1; n++; end
    chk("coll_halt_after_step", 32'(halted), 32'd1);
    chk("coll_one_rise", 32'(n_rise - r0), 32'd1);
    @(posedge clk_in); #1;
    chk("coll_then_run", 32'(dut.u_runctl.state_q), 32'(ST_RUN));
    step_req = 1'b0;
    repeat (4) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
